brg_mod_sequencer: RTL and testbench

Modulation sequencer and bit-timing controller for the eUSCI_A baud-rate generator. It latches the UCBRSx/UCBRFx/UCOS16 settings at each frame start and counts prescaler periods. It drives the prescaler's `m1`/`m2` modulation inputs period by period and issues the bit-period and oversample strobes consumed by the UART TX/RX engines. It sits between the eUSCI register file, the BRG prescaler and the UART shift logic.

---
 rtl/brg_mod_sequencer_if.sv | 23 ++
 rtl/brg_mod_sequencer.sv | 83 ++++++++
 tb/tb_brg_mod_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/brg_mod_sequencer_if.sv
// brg_mod_sequencer_if: control inputs and modulation/strobe outputs of the BRG modulation sequencer
interface brg_mod_sequencer_if;
  logic       UCABEN;
  logic       FrameStart;
  logic       PrescaleTick;
  logic       UCOS16;
  logic [7:0] UCBRSx;
  logic [3:0] UCBRFx;
  logic       m1;
  logic       m2;
  logic       BitTick;
  logic       OsTick;
  logic       SampleTick;
  logic       Busy;
  modport master (
    output UCABEN, FrameStart, PrescaleTick, UCOS16, UCBRSx, UCBRFx,
    input  m1, m2, BitTick, OsTick, SampleTick, Busy
  );
  modport slave (
    input  UCABEN, FrameStart, PrescaleTick, UCOS16, UCBRSx, UCBRFx,
    output m1, m2, BitTick, OsTick, SampleTick, Busy
  );
endinterface

// File: rtl/brg_mod_sequencer.sv
// brg_mod_sequencer: eUSCI_A BRG modulation sequencer and bit-timing strobes; BRG_SEQ_MIDSAMPLE_EN enables the mid-bit SampleTick
module brg_mod_sequencer #(
  parameter int OS_LEN = 16
) (
  input logic                BRCLK,
  input logic                reset,
  brg_mod_sequencer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [3:0] OS_LAST = 4'(OS_LEN - 1);
  logic [0:0] state;
  logic [7:0] s_brs;
  logic [3:0] s_brf;
  logic       s_os16;
  logic [2:0] bit_idx;
  logic [3:0] os_cnt;
  logic       m1_q, m2_q, bit_q, os_q, smp_q;
  logic       os_wrap;
  logic [3:0] os_nxt;
  logic [2:0] bit_nxt;
  logic       m1_nxt, m2_nxt, smp_nxt, fs_m1;
  // post-tick counters and the modulation/strobe values they imply
  always_comb begin
    os_wrap = s_os16 ? (os_cnt == OS_LAST) : 1'b1;
    os_nxt  = (s_os16 && !os_wrap) ? os_cnt + 4'd1 : 4'd0;
    bit_nxt = os_wrap ? bit_idx + 3'd1 : bit_idx;
    m1_nxt  = s_os16 ? (os_nxt < s_brf) : s_brs[bit_nxt];
    m2_nxt  = s_os16 && (os_nxt == OS_LAST) && s_brs[bit_nxt];
`ifdef BRG_SEQ_MIDSAMPLE_EN
    smp_nxt = s_os16 ? (os_nxt >= 4'd7 && os_nxt <= 4'd9) : 1'b1;
`else
    smp_nxt = 1'b0;
`endif
    fs_m1   = bus.UCOS16 ? (bus.UCBRFx != 4'd0) : bus.UCBRSx[0];
  end
  // frame control, counters, and registered modulation/strobe outputs on the falling BRCLK edge
  always_ff @(negedge BRCLK) begin
    if (reset || !bus.UCABEN) begin
      state   <= IDLE;
      s_brs   <= '0;
      s_brf   <= '0;
      s_os16  <= 1'b0;
      bit_idx <= '0;
      os_cnt  <= '0;
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      bit_q   <= 1'b0;
      os_q    <= 1'b0;
      smp_q   <= 1'b0;
    end else if (bus.FrameStart) begin
      state   <= RUN;
      s_brs   <= bus.UCBRSx;
      s_brf   <= bus.UCBRFx;
      s_os16  <= bus.UCOS16;
      bit_idx <= '0;
      os_cnt  <= '0;
      m1_q    <= fs_m1;
      m2_q    <= 1'b0;
      bit_q   <= 1'b0;
      os_q    <= 1'b0;
      smp_q   <= 1'b0;
    end else if (state == RUN && bus.PrescaleTick) begin
      bit_idx <= bit_nxt;
      os_cnt  <= os_nxt;
      m1_q    <= m1_nxt;
      m2_q    <= m2_nxt;
      bit_q   <= os_wrap;
      os_q    <= 1'b1;
      smp_q   <= smp_nxt;
    end else begin
      bit_q   <= 1'b0;
      os_q    <= 1'b0;
      smp_q   <= 1'b0;
    end
  end
  assign bus.m1         = m1_q;
  assign bus.m2         = m2_q;
  assign bus.BitTick    = bit_q;
  assign bus.OsTick     = os_q;
  assign bus.SampleTick = smp_q;
  assign bus.Busy       = (state == RUN);
endmodule

// File: tb/tb_brg_mod_sequencer.sv
// tb_brg_mod_sequencer: scoreboard bench comparing the sequencer against a tick-count reference model
module tb_brg_mod_sequencer;
  logic BRCLK = 1'b0;
  logic reset = 1'b1;
  always #5 BRCLK = ~BRCLK;
  brg_mod_sequencer_if bus();
  brg_mod_sequencer #(.OS_LEN(16)) dut (.BRCLK(BRCLK), .reset(reset), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int bt_seen = 0, ot_seen = 0, st_seen = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp, mon_act;
  logic       reg_os16 = 1'b0;
  logic [7:0] reg_brs = 8'h00;
  logic [3:0] reg_brf = 4'h0;
  logic       m_run = 1'b0;
  logic [7:0] m_brs = 8'h00;
  logic [3:0] m_brf = 4'h0;
  logic       m_os16 = 1'b0;
  int         m_n = 0;
  logic [5:0] m_out;
  // model: a frame is just a count of prescaler periods since FrameStart
  task automatic model(input logic r, input logic en, input logic fs, input logic pt);
    logic tick, m1, m2, bt, st;
    int os, bi;
    tick = 1'b0;
    if (r || !en) begin
      m_run = 1'b0;
      m_n = 0;
    end else if (fs) begin
      m_run = 1'b1;
      m_brs = reg_brs;
      m_brf = reg_brf;
      m_os16 = reg_os16;
      m_n = 0;
    end else if (m_run && pt) begin
      m_n = (m_n + 1) % 128;
      tick = 1'b1;
    end
    if (!m_run) m_out = 6'b0;
    else begin
      os = m_n % 16;
      bi = m_os16 ? (m_n / 16) % 8 : m_n % 8;
      m1 = m_os16 ? (os < int'(m_brf)) : m_brs[bi];
      m2 = m_os16 && os == 15 && m_brs[bi];
      bt = tick && (!m_os16 || os == 0);
`ifdef BRG_SEQ_MIDSAMPLE_EN
      st = tick && (!m_os16 || (os >= 7 && os <= 9));
`else
      st = 1'b0;
`endif
      m_out = {m1, m2, bt, tick, st, 1'b1};
    end
  endtask
  task automatic drive(input logic r, input logic en, input logic fs, input logic pt);
    @(posedge BRCLK);
    #1;
    reset = r;
    bus.UCABEN = en;
    bus.FrameStart = fs;
    bus.PrescaleTick = pt;
    bus.UCOS16 = reg_os16;
    bus.UCBRSx = reg_brs;
    bus.UCBRFx = reg_brf;
    model(r, en, fs, pt);
    exp_q.push_back(m_out);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask
  task automatic settle();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge BRCLK);
    #2;
  endtask
  task automatic check_cnt(input string nm, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic clr_cnt();
    bt_seen = 0;
    ot_seen = 0;
    st_seen = 0;
  endtask
  // monitor: every sampled cycle owed an expectation is compared here
  initial forever begin
    @(posedge BRCLK);
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {bus.m1, bus.m2, bus.BitTick, bus.OsTick, bus.SampleTick, bus.Busy};
      compared++;
      bt_seen += int'(bus.BitTick);
      ot_seen += int'(bus.OsTick);
      st_seen += int'(bus.SampleTick);
      if (mon_act !== mon_exp) begin
        mismatched++;
        $display("FAIL outputs{m1,m2,bit,os,smp,busy} @%0t: got %b want %b", $time, mon_act, mon_exp);
      end
    end
  end
  initial begin
    bus.UCABEN = 1'b0;
    bus.FrameStart = 1'b0;
    bus.PrescaleTick = 1'b0;
    bus.UCOS16 = 1'b0;
    bus.UCBRSx = 8'h00;
    bus.UCBRFx = 4'h0;
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    clr_cnt();
    reg_os16 = 1'b0; reg_brs = 8'hD6; reg_brf = 4'd0;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(10);
    settle();
    check_cnt("bittick_os16_0", bt_seen, 10);
    check_cnt("ostick_os16_0", ot_seen, 10);
    clr_cnt();
    reg_os16 = 1'b1; reg_brs = 8'h01; reg_brf = 4'd5;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(32);
    settle();
    check_cnt("bittick_os16_1", bt_seen, 2);
    check_cnt("ostick_os16_1", ot_seen, 32);
`ifdef BRG_SEQ_MIDSAMPLE_EN
    check_cnt("sampletick_os16_1", st_seen, 6);
`else
    check_cnt("sampletick_off", st_seen, 0);
`endif
    ticks(5);
    reg_brs = 8'hA5;
    clr_cnt();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    check_cnt("fs_pt_collision_strobes", ot_seen, 0);
    ticks(3);
    reg_os16 = 1'b0; reg_brs = 8'hFF;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(3);
    reg_brs = 8'h00;
    ticks(4);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(3);
    reg_os16 = 1'b1; reg_brf = 4'd3;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(9);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    clr_cnt();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check_cnt("tick_after_reset", ot_seen, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(4);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    ticks(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        reg_os16 = 1'($urandom);
        reg_brs = 8'($urandom);
        reg_brf = 4'($urandom);
      end
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 49) != 0),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0));
    end
    settle();
    check_cnt("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
